alu_share_arbiter: RTL and testbench

//  Shares the single combinational ALU between two requesters (r0: main datapath,
//  r1: auxiliary unit, e.g. branch compare). Round-robin arbitrates, latches the

---
 rtl/alu_share_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Shares one combinational ALU between two requesters (r0: main datapath,
// r1: auxiliary unit). A round-robin arbiter picks a winner in IDLE, the
// winner's control/operands are latched into the op registers, which drive
// the ALU for one EXEC cycle. The ALU result is registered and returned to
// the owner over a valid/ready response handshake. Only one op is in flight,
// so each op takes at least three cycles (IDLE -> EXEC -> RESP).
//
// Optional feature macro: ALU_ARB_OPCHK_EN
//   When defined, an accepted op whose control is not one of
//   {AND=0, OR=1, ADD=2, SUB=6, SLT=7, NOR=12} is rejected. In that case the
//   op registers are left untouched, EXEC is skipped and the response carries
//   rsp_err=1, rsp_data=0, rsp_zero=1. When undefined, every control value
//   goes to the ALU and rsp_err is always 0.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   rN_valid/ready        requester N op handshake (ready is combinational,
//                         high only in IDLE for the granted requester)
//   rN_ctl, rN_a, rN_b    requester N ALU control and operands
//   rsp_valid/ready       response handshake to the owning requester
//   rsp_id                owner of the response (0/1)
//   rsp_data, rsp_zero    registered ALU result and zero flag
//   rsp_err               op rejected (only with ALU_ARB_OPCHK_EN)
//   alu_ctl, alu_a, alu_b op registers driving the shared ALU
//   alu_out, alu_zero     shared ALU result and zero flag
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int CTL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [CTL_W-1:0] r0_ctl,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [CTL_W-1:0] r1_ctl,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    output logic             rsp_valid,
    output logic             rsp_id,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [CTL_W-1:0] alu_ctl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e           state_q,      state_d;
    logic [CTL_W-1:0] op_ctl_q,     op_ctl_d;
    logic [WIDTH-1:0] op_a_q,       op_a_d;
    logic [WIDTH-1:0] op_b_q,       op_b_d;
    logic             last_grant_q, last_grant_d;
    logic             rsp_valid_q,  rsp_valid_d;
    logic             rsp_id_q,     rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q,   rsp_data_d;
    logic             rsp_zero_q,   rsp_zero_d;
    logic             rsp_err_q,    rsp_err_d;

    logic             grant_vld_s;
    logic             grant_id_s;
    logic [CTL_W-1:0] sel_ctl_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;

`ifdef ALU_ARB_OPCHK_EN
    // Controls the shared ALU actually implements.
    function automatic logic ctl_legal(input logic [CTL_W-1:0] ctl);
        logic ok;
        case (ctl)
            CTL_W'(0), CTL_W'(1), CTL_W'(2),
            CTL_W'(6), CTL_W'(7), CTL_W'(12): ok = 1'b1;
            default:                          ok = 1'b0;
        endcase
        return ok;
    endfunction
`endif

    // Round-robin grant selection: on a tie the requester that did not win last time wins.
    always_comb begin
        grant_vld_s = r0_valid | r1_valid;
        if (r0_valid && r1_valid) begin
            grant_id_s = ~last_grant_q;
        end else if (r1_valid) begin
            grant_id_s = 1'b1;
        end else begin
            grant_id_s = 1'b0;
        end
        if (grant_id_s) begin
            sel_ctl_s = r1_ctl;
            sel_a_s   = r1_a;
            sel_b_s   = r1_b;
        end else begin
            sel_ctl_s = r0_ctl;
            sel_a_s   = r0_a;
            sel_b_s   = r0_b;
        end
    end

    // Next-state, op-register and response-register logic.
    always_comb begin
        state_d      = state_q;
        op_ctl_d     = op_ctl_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        r0_ready     = 1'b0;
        r1_ready     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld_s) begin
                    r0_ready     = ~grant_id_s;
                    r1_ready     = grant_id_s;
                    last_grant_d = grant_id_s;
                    rsp_id_d     = grant_id_s;
`ifdef ALU_ARB_OPCHK_EN
                    if (ctl_legal(sel_ctl_s)) begin
                        op_ctl_d = sel_ctl_s;
                        op_a_d   = sel_a_s;
                        op_b_d   = sel_b_s;
                        state_d  = ST_EXEC;
                    end else begin
                        // Rejected op: answer straight away, ALU inputs untouched.
                        rsp_data_d  = '0;
                        rsp_zero_d  = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end
`else
                    op_ctl_d = sel_ctl_s;
                    op_a_d   = sel_a_s;
                    op_b_d   = sel_b_s;
                    state_d  = ST_EXEC;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                rsp_data_d  = alu_out;
                rsp_zero_d  = alu_zero;
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_ctl_q     <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_ctl_q     <= op_ctl_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_ctl   = op_ctl_q;
    assign alu_a     = op_a_q;
    assign alu_b     = op_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
`ifdef ALU_ARB_OPCHK_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
// Directed bench for alu_share_arbiter with a small behavioural ALU attached
// to the alu_* ports. Inputs are driven and outputs sampled on the falling
// edge (combinational readies are sampled 1 time unit later).
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_valid, r0_ready, r1_valid, r1_ready;
    logic [3:0]  r0_ctl, r1_ctl;
    logic [31:0] r0_a, r0_b, r1_a, r1_b;
    logic        rsp_valid, rsp_id, rsp_ready, rsp_zero, rsp_err;
    logic [31:0] rsp_data;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_a, alu_b, alu_out;
    logic        alu_zero;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(32), .CTL_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_ctl(r0_ctl), .r0_a(r0_a), .r0_b(r0_b),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_ctl(r1_ctl), .r1_a(r1_a), .r1_b(r1_b),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_zero(alu_zero)
    );

    // Shared combinational ALU seen by the arbiter.
    always_comb begin
        case (alu_ctl)
            4'd0:    alu_out = alu_a & alu_b;
            4'd1:    alu_out = alu_a | alu_b;
            4'd2:    alu_out = alu_a + alu_b;
            4'd6:    alu_out = alu_a - alu_b;
            4'd7:    alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            4'd12:   alu_out = ~(alu_a | alu_b);
            default: alu_out = 32'd0;
        endcase
        alu_zero = (alu_out == 32'd0);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_r0(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        r0_valid = v; r0_ctl = c; r0_a = a; r0_b = b;
    endtask

    task automatic set_r1(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        r1_valid = v; r1_ctl = c; r1_a = a; r1_b = b;
    endtask

    initial begin
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        set_r0(1'b0, 4'd0, 32'd0, 32'd0);
        set_r1(1'b0, 4'd0, 32'd0, 32'd0);
        step(); step();

        // Reset state
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_rsp_data",  rsp_data,       32'd0);
        check_val("rst_rsp_err",   32'(rsp_err),   32'd0);
        check_val("rst_alu_ctl",   32'(alu_ctl),   32'd0);
        check_val("rst_r0_ready",  32'(r0_ready),  32'd0);
        rst_n = 1'b1;

        // 1: r0 ADD 5+7
        set_r0(1'b1, 4'd2, 32'd5, 32'd7);
        #1;
        check_val("t1_r0_ready", 32'(r0_ready), 32'd1);
        check_val("t1_r1_ready", 32'(r1_ready), 32'd0);
        step();
        r0_valid = 1'b0;
        #1;
        check_val("t1_exec_ready", 32'(r0_ready),  32'd0);
        check_val("t1_exec_valid", 32'(rsp_valid), 32'd0);
        check_val("t1_alu_a",      alu_a,          32'd5);
        step();
        check_val("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        check_val("t1_rsp_id",    32'(rsp_id),    32'd0);
        check_val("t1_rsp_data",  rsp_data,       32'd12);
        check_val("t1_rsp_zero",  32'(rsp_zero),  32'd0);
        check_val("t1_rsp_err",   32'(rsp_err),   32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_val("t1_done_valid", 32'(rsp_valid), 32'd0);

        // 2: tie right after reset -> r0 first
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_r0(1'b1, 4'd6, 32'd9, 32'd9);
        set_r1(1'b1, 4'd1, 32'h0000_00F0, 32'h0000_000F);
        #1;
        check_val("t2_tie_r0_ready", 32'(r0_ready), 32'd1);
        check_val("t2_tie_r1_ready", 32'(r1_ready), 32'd0);
        step();
        r0_valid = 1'b0;
        #1;
        check_val("t2_exec_r1_ready", 32'(r1_ready), 32'd0);
        step();
        check_val("t2_sub_id",   32'(rsp_id),   32'd0);
        check_val("t2_sub_data", rsp_data,      32'd0);
        check_val("t2_sub_zero", 32'(rsp_zero), 32'd1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        #1;
        check_val("t2_r1_ready", 32'(r1_ready), 32'd1);
        step();
        r1_valid = 1'b0;
        step();
        check_val("t2_or_id",   32'(rsp_id), 32'd1);
        check_val("t2_or_data", rsp_data,    32'h0000_00FF);
        rsp_ready = 1'b1;
        step();
        // Both held valid: grants alternate 0,1,0,1
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_val("t2_alt_r0_ready", 32'(r0_ready), 32'((k % 2) == 0));
            check_val("t2_alt_r1_ready", 32'(r1_ready), 32'((k % 2) == 1));
            step();
            step();
            check_val("t2_alt_rsp_id", 32'(rsp_id), 32'(k % 2));
            step();
        end
        rsp_ready = 1'b0;

        // 3: response back-pressure; last grant was r1 so tie -> r0
        set_r0(1'b1, 4'd2, 32'd1, 32'd2);
        set_r1(1'b1, 4'd7, 32'd3, 32'd4);
        #1;
        check_val("t3_r0_ready", 32'(r0_ready), 32'd1);
        step();
        r0_valid = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            #1;
            check_val("t3_hold_valid",    32'(rsp_valid), 32'd1);
            check_val("t3_hold_data",     rsp_data,       32'd3);
            check_val("t3_hold_id",       32'(rsp_id),    32'd0);
            check_val("t3_hold_r1_ready", 32'(r1_ready),  32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        #1;
        check_val("t3_idle_valid",   32'(rsp_valid), 32'd0);
        check_val("t3_idle_r1_ready", 32'(r1_ready), 32'd1);

        // 5: r1 SLT 3<4 then 4<3
        step();
        set_r1(1'b1, 4'd7, 32'd4, 32'd3);
        step();
        check_val("t5_slt1_id",   32'(rsp_id),   32'd1);
        check_val("t5_slt1_data", rsp_data,      32'd1);
        check_val("t5_slt1_zero", 32'(rsp_zero), 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        #1;
        check_val("t5_r1_ready", 32'(r1_ready), 32'd1);
        step();
        r1_valid = 1'b0;
        step();
        check_val("t5_slt0_data", rsp_data,      32'd0);
        check_val("t5_slt0_zero", 32'(rsp_zero), 32'd1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // 4: reset during EXEC
        set_r0(1'b1, 4'd2, 32'd5, 32'd7);
        step();
        r0_valid = 1'b0;
        rst_n = 1'b0;
        step();
        check_val("t4e_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("t4e_alu_a",     alu_a,          32'd0);
        check_val("t4e_alu_ctl",   32'(alu_ctl),   32'd0);
        rst_n = 1'b1;
        // reset during RESP
        r0_valid = 1'b1;
        step();
        r0_valid = 1'b0;
        step();
        check_val("t4r_pre_data", rsp_data, 32'd12);
        rst_n = 1'b0;
        step();
        check_val("t4r_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("t4r_rsp_data",  rsp_data,       32'd0);
        check_val("t4r_rsp_id",    32'(rsp_id),    32'd0);
        check_val("t4r_rsp_zero",  32'(rsp_zero),  32'd0);
        check_val("t4r_alu_b",     alu_b,          32'd0);
        rst_n = 1'b1;
        set_r0(1'b1, 4'd0, 32'h0000_000F, 32'h0000_0003);
        set_r1(1'b1, 4'd1, 32'd1, 32'd2);
        #1;
        check_val("t4_tie_r0_ready", 32'(r0_ready), 32'd1);
        check_val("t4_tie_r1_ready", 32'(r1_ready), 32'd0);
        step();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        step();
        check_val("t4_and_data", rsp_data, 32'd3);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // 6: illegal control 5
        set_r0(1'b1, 4'd5, 32'd1, 32'd1);
        #1;
        check_val("t6_r0_ready", 32'(r0_ready), 32'd1);
        step();
        r0_valid = 1'b0;
`ifdef ALU_ARB_OPCHK_EN
        check_val("t6_rsp_valid", 32'(rsp_valid), 32'd1);
        check_val("t6_rsp_err",   32'(rsp_err),   32'd1);
        check_val("t6_rsp_data",  rsp_data,       32'd0);
        check_val("t6_rsp_zero",  32'(rsp_zero),  32'd1);
        check_val("t6_rsp_id",    32'(rsp_id),    32'd0);
        check_val("t6_alu_a",     alu_a,          32'h0000_000F);
        check_val("t6_alu_ctl",   32'(alu_ctl),   32'd0);
`else
        check_val("t6_exec_valid", 32'(rsp_valid), 32'd0);
        check_val("t6_alu_ctl",    32'(alu_ctl),   32'd5);
        step();
        check_val("t6_rsp_valid", 32'(rsp_valid), 32'd1);
        check_val("t6_rsp_err",   32'(rsp_err),   32'd0);
        check_val("t6_rsp_data",  rsp_data,       32'd0);
        check_val("t6_rsp_zero",  32'(rsp_zero),  32'd1);
`endif
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_val("t6_done_valid", 32'(rsp_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
